// File: rtl/ctl_table_banks_pkg.sv
// Shared constants for the host-written controller, duty and filter tables.
// Bank selects, read latency and default geometry used by the RTL and its bench.
package ctl_table_banks_pkg;

  localparam logic [1:0] SEL_CNT    = 2'd0;
  localparam logic [1:0] SEL_DUTY   = 2'd1;
  localparam logic [1:0] SEL_FILTER = 2'd2;

  // Edges between the address-capture edge and data appearing on a read port
  localparam int READ_LATENCY = 2;

  localparam int DEPTH_DEFAULT   = 249;
  localparam int CNT_AW_DEFAULT  = 8;
  localparam int DUTY_AW_DEFAULT = 15;
  localparam int HOST_AW         = 14;

  // Modulation stage: transducer phase plus its filter offset, wrapping at 256
  function automatic logic [7:0] add_phase(input logic [7:0] phase_in, input logic [7:0] offset);
    return phase_in + offset;
  endfunction

endpackage

// File: rtl/ctl_table_banks_byte_packed_ram.sv
// Simple dual-port RAM: 16-bit word writes, 8-bit entry reads with a fixed
// READ_LATENCY pipeline after the read-first array access.
module byte_packed_ram
  import ctl_table_banks_pkg::*;
#(
  parameter int WORDS = 125,
  parameter int WAW   = 7
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           WE,
  input  logic [WAW-1:0] WADDR,
  input  logic [15:0]    WDATA,
  input  logic [WAW:0]   RIDX,
  input  logic           RVALID,
  output logic [7:0]     DOUT
);

  logic [15:0]    mem [WORDS];
  logic [15:0]    word_reg;
  logic           lane_reg;
  logic           ok_reg;
  logic [7:0]     pipe_reg [READ_LATENCY];
  logic [WAW-1:0] rd_word;

  // Out-of-range indices read word 0 and are zeroed downstream, keeping the array index legal
  assign rd_word = RVALID ? RIDX[WAW:1] : '0;

  always_ff @(posedge CLK) begin
    if (WE) mem[WADDR] <= WDATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_reg <= '0;
      lane_reg <= 1'b0;
      ok_reg   <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_reg[i] <= '0;
    end else begin
      word_reg <= mem[rd_word];
      lane_reg <= RIDX[0];
      ok_reg   <= RVALID;
      if (!ok_reg)       pipe_reg[0] <= '0;
      else if (lane_reg) pipe_reg[0] <= word_reg[15:8];
      else               pipe_reg[0] <= word_reg[7:0];
      for (int i = 1; i < READ_LATENCY; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign DOUT = pipe_reg[READ_LATENCY-1];

endmodule

// File: rtl/ctl_table_banks.sv
// Controller register bank plus byte-packed duty and filter tables, all written
// through one host port and read through fixed-latency, always-valid ports.
module ctl_table_banks
  import ctl_table_banks_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int CNT_AW  = CNT_AW_DEFAULT,
  parameter int DUTY_AW = DUTY_AW_DEFAULT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               HOST_WE,
  input  logic [1:0]         HOST_SEL,
  input  logic [HOST_AW-1:0] HOST_ADDR,
  input  logic [15:0]        HOST_DIN,
  input  logic               CNT_WE,
  input  logic [CNT_AW-1:0]  CNT_ADDR,
  input  logic [15:0]        CNT_DIN,
  output logic [15:0]        CNT_DOUT,
  input  logic [DUTY_AW-1:0] DUTY_ADDR,
  output logic [7:0]         DUTY_DOUT,
  input  logic [7:0]         FILTER_IDX,
  output logic [7:0]         FILTER_DOUT
);

  localparam int FILT_WORDS = (DEPTH + 1) / 2;
  localparam int FILT_WAW   = $clog2(FILT_WORDS);
  localparam int DUTY_WAW   = DUTY_AW - 1;

  logic host_cnt_we;
  logic host_duty_we;
  logic host_filt_we;
  logic filt_rd_ok;

  assign host_cnt_we  = HOST_WE && (HOST_SEL == SEL_CNT) && ((HOST_ADDR >> CNT_AW) == '0);
  assign host_duty_we = HOST_WE && (HOST_SEL == SEL_DUTY) && ((HOST_ADDR >> DUTY_WAW) == '0);
  assign host_filt_we = HOST_WE && (HOST_SEL == SEL_FILTER) && (HOST_ADDR < HOST_AW'(FILT_WORDS));
  assign filt_rd_ok   = FILTER_IDX < 8'(DEPTH);

  // Controller bank: both writes share one block so a same-address collision
  // resolves to the controller, which is written last.
  logic [15:0] cnt_mem [2**CNT_AW];
  logic [15:0] cnt_word_reg;
  logic [15:0] cnt_pipe_reg [READ_LATENCY];

  always_ff @(posedge CLK) begin
    if (host_cnt_we) cnt_mem[HOST_ADDR[CNT_AW-1:0]] <= HOST_DIN;
    if (CNT_WE)      cnt_mem[CNT_ADDR] <= CNT_DIN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_word_reg <= '0;
      for (int i = 0; i < READ_LATENCY; i++) cnt_pipe_reg[i] <= '0;
    end else begin
      cnt_word_reg    <= cnt_mem[CNT_ADDR];
      cnt_pipe_reg[0] <= cnt_word_reg;
      for (int i = 1; i < READ_LATENCY; i++) cnt_pipe_reg[i] <= cnt_pipe_reg[i-1];
    end
  end

  assign CNT_DOUT = cnt_pipe_reg[READ_LATENCY-1];

  byte_packed_ram #(
    .WORDS (2**DUTY_WAW),
    .WAW   (DUTY_WAW)
  ) u_duty (
    .CLK    (CLK),
    .RST    (RST),
    .WE     (host_duty_we),
    .WADDR  (HOST_ADDR[DUTY_WAW-1:0]),
    .WDATA  (HOST_DIN),
    .RIDX   (DUTY_ADDR),
    .RVALID (1'b1),
    .DOUT   (DUTY_DOUT)
  );

  byte_packed_ram #(
    .WORDS (FILT_WORDS),
    .WAW   (FILT_WAW)
  ) u_filter (
    .CLK    (CLK),
    .RST    (RST),
    .WE     (host_filt_we),
    .WADDR  (HOST_ADDR[FILT_WAW-1:0]),
    .WDATA  (HOST_DIN),
    .RIDX   (FILTER_IDX),
    .RVALID (filt_rd_ok),
    .DOUT   (FILTER_DOUT)
  );

endmodule

// File: tb/tb_ctl_table_banks.sv
// Randomized scoreboard bench for ctl_table_banks against an entry-level table model.
module tb_ctl_table_banks;
  import ctl_table_banks_pkg::*;

  localparam int NDEPTH = 249;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        HOST_WE = 1'b0;
  logic [1:0]  HOST_SEL = 2'd0;
  logic [13:0] HOST_ADDR = '0;
  logic [15:0] HOST_DIN = '0;
  logic        CNT_WE = 1'b0;
  logic [7:0]  CNT_ADDR = '0;
  logic [15:0] CNT_DIN = '0;
  logic [15:0] CNT_DOUT;
  logic [14:0] DUTY_ADDR = '0;
  logic [7:0]  DUTY_DOUT;
  logic [7:0]  FILTER_IDX = '0;
  logic [7:0]  FILTER_DOUT;

  ctl_table_banks dut (
    .CLK(CLK), .RST(RST),
    .HOST_WE(HOST_WE), .HOST_SEL(HOST_SEL), .HOST_ADDR(HOST_ADDR), .HOST_DIN(HOST_DIN),
    .CNT_WE(CNT_WE), .CNT_ADDR(CNT_ADDR), .CNT_DIN(CNT_DIN), .CNT_DOUT(CNT_DOUT),
    .DUTY_ADDR(DUTY_ADDR), .DUTY_DOUT(DUTY_DOUT),
    .FILTER_IDX(FILTER_IDX), .FILTER_DOUT(FILTER_DOUT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int port;
    int due;
    int exp;
    int addr;
    int phase;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Reference tables, entry-granular; *_k marks entries that have been written
  logic [15:0] cnt_m  [256];
  bit          cnt_k  [256];
  logic [7:0]  duty_m [32768];
  bit          duty_k [32768];
  logic [7:0]  filt_m [NDEPTH];
  bit          filt_k [NDEPTH];

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endfunction

  // One cycle of stimulus: expectations come from the model before this cycle's writes land
  task automatic drive(input bit hwe, input int hsel, input int haddr, input int hdin,
                       input bit cwe, input int caddr, input int cdin,
                       input int daddr, input int fidx);
    exp_t e;
    HOST_WE = hwe; HOST_SEL = 2'(hsel); HOST_ADDR = 14'(haddr); HOST_DIN = 16'(hdin);
    CNT_WE = cwe; CNT_ADDR = 8'(caddr); CNT_DIN = 16'(cdin);
    DUTY_ADDR = 15'(daddr); FILTER_IDX = 8'(fidx);
    e.due = cyc + 3;
    e.phase = int'($urandom_range(0, 255));
    if (cnt_k[caddr]) begin
      e.port = 0; e.exp = int'(cnt_m[caddr]); e.addr = caddr; sb.push_back(e);
    end
    if (duty_k[daddr]) begin
      e.port = 1; e.exp = int'(duty_m[daddr]); e.addr = daddr; sb.push_back(e);
    end
    if (fidx >= NDEPTH) begin
      e.port = 2; e.exp = 0; e.addr = fidx; sb.push_back(e);
    end else if (filt_k[fidx]) begin
      e.port = 2; e.exp = int'(filt_m[fidx]); e.addr = fidx; sb.push_back(e);
    end
    if (hwe) begin
      if (hsel == 0 && haddr < 256) begin
        cnt_m[haddr] = 16'(hdin); cnt_k[haddr] = 1'b1;
      end else if (hsel == 1 && haddr < 16384) begin
        duty_m[2*haddr] = 8'(hdin); duty_m[2*haddr+1] = 8'(hdin >> 8);
        duty_k[2*haddr] = 1'b1; duty_k[2*haddr+1] = 1'b1;
      end else if (hsel == 2 && haddr < (NDEPTH + 1) / 2) begin
        filt_m[2*haddr] = 8'(hdin); filt_k[2*haddr] = 1'b1;
        if (2*haddr + 1 < NDEPTH) begin
          filt_m[2*haddr+1] = 8'(hdin >> 8); filt_k[2*haddr+1] = 1'b1;
        end
      end
    end
    if (cwe) begin
      cnt_m[caddr] = 16'(cdin); cnt_k[caddr] = 1'b1;
    end
    @(negedge CLK);
  endtask

  // Monitor: compares every read port whose expected data is due this cycle
  exp_t m;
  logic [7:0] ph_out;
  always @(negedge CLK) begin
    if (!RST) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        m = sb.pop_front();
        if (m.due < cyc) check("stale_entry", m.due, cyc);
        else if (m.port == 0) check($sformatf("cnt[%0d]", m.addr), int'(CNT_DOUT), m.exp);
        else if (m.port == 1) check($sformatf("duty[%0d]", m.addr), int'(DUTY_DOUT), m.exp);
        else begin
          check($sformatf("filter[%0d]", m.addr), int'(FILTER_DOUT), m.exp);
          ph_out = add_phase(8'(m.phase), FILTER_DOUT);
          check($sformatf("phase[%0d] in=%0d", m.addr, m.phase), int'(ph_out), (m.phase + m.exp) % 256);
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cnt"}, int'(CNT_DOUT), 0);
    check({tag, "_duty"}, int'(DUTY_DOUT), 0);
    check({tag, "_filter"}, int'(FILTER_DOUT), 0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check_outputs_zero("reset");
    RST = 1'b0;

    for (int i = 0; i < 256; i++)
      drive(1, SEL_CNT, i, (i == 7) ? 16'h0001 : int'($urandom_range(0, 65535)), 0, i, 0, 0, 0);
    for (int w = 0; w < (NDEPTH + 1) / 2; w++)
      drive(1, SEL_FILTER, w, int'($urandom_range(0, 65535)), 0, 0, 0, 0, 0);
    for (int w = 0; w < 64; w++)
      drive(1, SEL_DUTY, w, int'($urandom_range(0, 65535)), 0, 0, 0, 0, 0);
    drive(1, SEL_DUTY, 5, 16'h1234, 0, 0, 0, 0, 0);

    // Writes that must leave every bank untouched
    drive(1, 3, 3, 16'hDEAD, 0, 3, 0, 0, 0);
    drive(1, SEL_CNT, 14'h103, 16'hBEEF, 0, 3, 0, 0, 0);
    drive(1, SEL_FILTER, 126, 16'hFFFF, 0, 3, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 3, 0, 10, 0);
    drive(0, 0, 0, 0, 0, 3, 0, 11, 0);

    for (int i = 0; i < NDEPTH; i++)
      drive(0, 0, 0, 0, 0, int'($urandom_range(0, 255)), 0, int'($urandom_range(0, 127)), i);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 249);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 255);

    // Same-address collision, then read-first on address 7
    drive(1, SEL_CNT, 3, 16'hAAAA, 1, 3, 16'h5555, 0, 0);
    drive(0, 0, 0, 0, 0, 3, 0, 0, 0);
    drive(1, SEL_CNT, 7, 16'h00FF, 0, 7, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 7, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      int hsel;
      int haddr;
      hsel = int'($urandom_range(0, 3));
      haddr = (hsel == 0) ? int'($urandom_range(0, 300)) :
              (hsel == 1) ? int'($urandom_range(0, 127)) :
              (hsel == 2) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 16383));
      drive($urandom_range(0, 1) == 1, hsel, haddr, int'($urandom_range(0, 65535)),
            $urandom_range(0, 3) == 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    // Reset in the middle of a filter sweep; contents must survive
    for (int i = 0; i < 40; i++) drive(0, 0, 0, 0, 0, i, 0, i, i);
    #2 RST = 1'b1;
    sb.delete();
    #1 check_outputs_zero("rst_async");
    @(negedge CLK);
    check_outputs_zero("rst_held");
    RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 1, 1);

    repeat (5) @(negedge CLK);
    if (sb.size() != 0) check("drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
